enc_binder_bank: RTL and testbench

- Parametrised, time-multiplexed binding bank for the sparse HDC encoder.
- Binds NUM_CH level hypervectors by channel-specific circular shifts taken from the shared SHIFTS table, starting at index SHIFT_BASE.
- Processes LANES channels per cycle through shared rotators, with start/busy/done handshake and selectable bind/unbind direction.
- Sits between the level-HV lookup and the bundling adder tree, and replaces fixed-size binder packs.

---
 rtl/enc_binder_pkg.sv | 30 +++
 rtl/enc_binder_bank_rotator.sv | 24 ++
 rtl/enc_binder_bank.sv | 136 +++++++++++++
 tb/tb_enc_binder_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_binder_pkg.sv
// rtl/enc_binder_pkg.sv - shared encoder constants, shift table and binder types
package enc_binder_pkg;

   // Hypervector width shared by the level lookup, binder and bundler.
   localparam int HV_DIM = 64;

   // Per-channel circular shift table; some entries exceed HV_DIM on purpose.
   localparam int NUM_SHIFTS = 64;
   localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
        3,  17,  29,  41,   5,  60,  12,  33,  48,   7,
       21,  55,   9,  38,   2,  63,  27,  14,  50,  36,
       44,  19,   6,  58,  31,  11,  46,  24,  53,   1,
       40,  15,  62,  28,   8,  35,  57,  23,  10,  49,
        0,  64,  70,   1,  63, 127,  13, 100,  37, 200,
       26,   4,  52,  18,  61,  30,  43,  16,  59,  22,
       39,  47,  34,  56
   };

   // Bits needed for a reduced rotate amount (0..HV_DIM-1).
   localparam int SHIFT_W = $clog2(HV_DIM);

   typedef logic [HV_DIM-1:0] hv_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } binder_state_t;

endpackage

// File: rtl/enc_binder_bank_rotator.sv
// rtl/enc_binder_bank_rotator.sv - combinational HV-wide circular rotate, runtime amount and direction
module enc_rotator
   import enc_binder_pkg::*;
(
   input  hv_t                data_i,
   input  logic [SHIFT_W-1:0] amt_i,
   input  logic               unbind_i,
   output hv_t                data_o
);

   // Complementary amount; amt_i = 0 makes this HV_DIM, which shifts everything out.
   logic [SHIFT_W:0] inv_amt;
   hv_t              rot_up;
   hv_t              rot_dn;

   // Bind moves bit j to (j+s), unbind pulls bit (j+s) down to j.
   always_comb begin
      inv_amt = (SHIFT_W+1)'(HV_DIM) - {1'b0, amt_i};
      rot_up  = (data_i << amt_i) | (data_i >> inv_amt);
      rot_dn  = (data_i >> amt_i) | (data_i << inv_amt);
      data_o  = unbind_i ? rot_dn : rot_up;
   end

endmodule

// File: rtl/enc_binder_bank.sv
// rtl/enc_binder_bank.sv - time-multiplexed channel binder sharing LANES rotators
module enc_binder_bank
   import enc_binder_pkg::*;
#(
   parameter int NUM_CH     = 10,
   parameter int LANES      = 2,
   parameter int SHIFT_BASE = 0
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           start_encoding,
   input  logic                           unbind,
   input  logic [NUM_CH-1:0][HV_DIM-1:0]  level_hv,
   output logic                           busy,
   output logic                           done,
   output logic                           shifted_valid,
   output logic [NUM_CH-1:0][HV_DIM-1:0]  shifted_hv
);

   localparam int G  = (NUM_CH + LANES - 1) / LANES;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("enc_binder_bank: NUM_CH must be at least 1");
   end
   if (LANES < 1 || LANES > NUM_CH) begin : g_bad_lanes
      $error("enc_binder_bank: LANES must be in 1..NUM_CH");
   end
   if (SHIFT_BASE < 0 || SHIFT_BASE + NUM_CH > NUM_SHIFTS) begin : g_bad_base
      $error("enc_binder_bank: SHIFT_BASE+NUM_CH exceeds the SHIFTS table");
   end

   binder_state_t state_q, state_d;
   logic [GW-1:0] g_q;
   logic          unbind_q;
   logic          valid_q;
   logic [NUM_CH-1:0][HV_DIM-1:0] snap_q;
   logic [NUM_CH-1:0][HV_DIM-1:0] shifted_q;

   logic               accept;
   logic               last_grp;
   logic [SHIFT_W-1:0] ch_shift [NUM_CH];
   int                 lane_c   [LANES];
   logic               lane_en  [LANES];
   logic [CW-1:0]      lane_idx [LANES];
   hv_t                lane_in  [LANES];
   logic [SHIFT_W-1:0] lane_amt [LANES];
   hv_t                lane_out [LANES];

   // Per-channel rotate amounts are elaboration constants, already reduced mod HV_DIM.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_shift
      assign ch_shift[i] = SHIFT_W'(SHIFTS[SHIFT_BASE + i] % HV_DIM);
   end

   assign accept   = (state_q == IDLE) && start_encoding;
   assign last_grp = (g_q == GW'(G - 1));

   // Lane k serves channel g*LANES+k; lanes past the last channel are gated and parked on channel 0.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_c[k]   = int'(g_q) * LANES + k;
         lane_en[k]  = (lane_c[k] < NUM_CH);
         lane_idx[k] = lane_en[k] ? CW'(lane_c[k]) : '0;
         lane_in[k]  = snap_q[lane_idx[k]];
         lane_amt[k] = ch_shift[lane_idx[k]];
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      enc_rotator u_rot (
         .data_i   (lane_in[k]),
         .amt_i    (lane_amt[k]),
         .unbind_i (unbind_q),
         .data_o   (lane_out[k])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one RUN cycle per group, then a single FIN cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_encoding) state_d = RUN;
         RUN:     if (last_grp)       state_d = FIN;
         FIN:                         state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   // Snapshot on accept, write active lanes each RUN cycle, advance the group counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         g_q       <= '0;
         unbind_q  <= 1'b0;
         valid_q   <= 1'b0;
         snap_q    <= '0;
         shifted_q <= '0;
      end else if (accept) begin
         g_q      <= '0;
         unbind_q <= unbind;
         valid_q  <= 1'b0;
         snap_q   <= level_hv;
      end else if (state_q == RUN) begin
         for (int k = 0; k < LANES; k++) begin
            if (lane_en[k]) shifted_q[lane_idx[k]] <= lane_out[k];
         end
         // Valid is raised on the edge entering FIN so it rises together with done.
         if (last_grp) valid_q <= 1'b1;
         else          g_q     <= g_q + 1'b1;
      end
   end

   assign shifted_valid = valid_q;
   assign shifted_hv    = shifted_q;

endmodule

// File: tb/tb_enc_binder_bank.sv
// tb/tb_enc_binder_bank.sv - self-checking bench for enc_binder_bank against a behavioural model
module tb_enc_binder_bank;
   import enc_binder_pkg::*;

   localparam int NUM_CH     = 10;
   localparam int LANES      = 4;
   localparam int SHIFT_BASE = 40;
   localparam int G          = (NUM_CH + LANES - 1) / LANES;

   typedef logic [NUM_CH-1:0][HV_DIM-1:0] bank_t;

   logic  clk = 1'b0;
   logic  nrst = 1'b0;
   logic  start_encoding = 1'b0;
   logic  unbind = 1'b0;
   bank_t level_hv = '0;
   logic  busy, done, shifted_valid;
   bank_t shifted_hv;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Model state: cycles since accepted start (0 = idle), snapshot, expected results.
   int    m_cnt = 0;
   bit    m_unb = 1'b0;
   bit    m_valid = 1'b0;
   bank_t m_snap = '0;
   bank_t m_hv = '0;

   enc_binder_bank #(
      .NUM_CH     (NUM_CH),
      .LANES      (LANES),
      .SHIFT_BASE (SHIFT_BASE)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .start_encoding (start_encoding),
      .unbind         (unbind),
      .level_hv       (level_hv),
      .busy           (busy),
      .done           (done),
      .shifted_valid  (shifted_valid),
      .shifted_hv     (shifted_hv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Bit-by-bit rotation straight from the index rule.
   function automatic hv_t rot_m(input hv_t v, input int unsigned s, input bit unb);
      hv_t o;
      int  r;
      r = int'(s % HV_DIM);
      o = '0;
      for (int j = 0; j < HV_DIM; j++) begin
         if (!unb) o[(j + r) % HV_DIM] = v[j];
         else      o[j] = v[(j + r) % HV_DIM];
      end
      return o;
   endfunction

   function automatic bank_t bind_all(input bank_t d, input bit unb);
      bank_t r;
      for (int c = 0; c < NUM_CH; c++) r[c] = rot_m(d[c], SHIFTS[SHIFT_BASE + c], unb);
      return r;
   endfunction

   // Behavioural model: result appears G+1 cycles after an accepted start.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_cnt = 0;
         m_valid = 1'b0;
         m_hv = '0;
         m_snap = '0;
      end else if (m_cnt == 0) begin
         if (start_encoding) begin
            m_snap = level_hv;
            m_unb = unbind;
            m_cnt = 1;
            m_valid = 1'b0;
         end
      end else if (m_cnt == G + 1) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == G + 1) begin
            m_hv = bind_all(m_snap, m_unb);
            m_valid = 1'b1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (chk_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_cnt >= 1 && m_cnt <= G));
            chk("cyc_done", 64'(done), 64'(m_cnt == G + 1));
            chk("cyc_valid", 64'(shifted_valid), 64'(m_valid));
            if (m_cnt == 0 || m_cnt == G + 1) begin
               for (int c = 0; c < NUM_CH; c++) chk($sformatf("cyc_hv%0d", c), shifted_hv[c], m_hv[c]);
            end
         end
      end
   end

   // One operation: pulse start, then wait (bounded) for done; ends at the done cycle.
   task automatic run_op(input bank_t d, input bit u, output int lat, output int bcnt);
      @(negedge clk);
      level_hv = d;
      unbind = u;
      start_encoding = 1'b1;
      @(negedge clk);
      start_encoding = 1'b0;
      level_hv = '0;
      lat = -1;
      bcnt = 0;
      for (int i = 1; i <= 20; i++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) begin
         failures++;
         $display("FAIL done_timeout actual=none expected=done within 20 cycles");
      end
   endtask

   bank_t onehot, bound, rnd, rbound, data_a, data_b;
   int    lat, bcnt, dcnt, dlat;

   initial begin
      // Reset held for 3 cycles, then idle with no start.
      nrst = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      chk_en = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_valid", 64'(shifted_valid), 64'd0);
      chk("idle_hv_or", 64'(|shifted_hv), 64'd0);

      // Basic bind of one-hot vectors.
      for (int c = 0; c < NUM_CH; c++) onehot[c] = hv_t'(1) << c;
      run_op(onehot, 1'b0, lat, bcnt);
      chk("bind_latency", 64'(lat), 64'd4);
      chk("bind_busy_cycles", 64'(bcnt), 64'd3);
      chk("bind_valid", 64'(shifted_valid), 64'd1);
      chk("bind_ch0", shifted_hv[0], 64'h0000_0000_0000_0001);
      chk("bind_ch2", shifted_hv[2], 64'h0000_0000_0000_0100);
      chk("bind_ch4", shifted_hv[4], 64'h0000_0000_0000_0008);
      chk("bind_ch7", shifted_hv[7], 64'h0000_0800_0000_0000);
      chk("bind_ch9", shifted_hv[9], 64'h0000_0000_0002_0000);
      chk("model_pin_ch5", m_hv[5], 64'h0000_0000_0000_0010);

      // Round trip on one-hot vectors.
      bound = bind_all(onehot, 1'b0);
      run_op(bound, 1'b1, lat, bcnt);
      chk("unbind_latency", 64'(lat), 64'd4);
      for (int c = 0; c < NUM_CH; c++) chk($sformatf("rt_onehot%0d", c), shifted_hv[c], onehot[c]);

      // Round trip on random sparse vectors; also overwrites a fully populated bank.
      for (int c = 0; c < NUM_CH; c++)
         for (int j = 0; j < HV_DIM; j++) rnd[c][j] = ($urandom_range(0, 99) < 5);
      run_op(rnd, 1'b0, lat, bcnt);
      rbound = bind_all(rnd, 1'b0);
      for (int c = 0; c < NUM_CH; c++) chk($sformatf("rnd_bind%0d", c), shifted_hv[c], rbound[c]);
      run_op(rbound, 1'b1, lat, bcnt);
      for (int c = 0; c < NUM_CH; c++) chk($sformatf("rnd_rt%0d", c), shifted_hv[c], rnd[c]);

      // Start while busy is ignored.
      for (int c = 0; c < NUM_CH; c++) begin
         data_a[c] = {$urandom, $urandom};
         data_b[c] = {$urandom, $urandom};
      end
      @(negedge clk);
      level_hv = data_a;
      unbind = 1'b0;
      start_encoding = 1'b1;
      dcnt = 0;
      dlat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start_encoding = (i == 2);
         level_hv = (i == 2) ? data_b : '0;
         unbind = (i == 2);
         if (done) begin
            dcnt++;
            if (dlat < 0) dlat = i;
            if (dcnt == 1) chk("busy_start_hv3", shifted_hv[3], rot_m(data_a[3], SHIFTS[SHIFT_BASE + 3], 1'b0));
         end
      end
      chk("busy_start_done_count", 64'(dcnt), 64'd1);
      chk("busy_start_done_cycle", 64'(dlat), 64'd4);
      run_op(data_b, 1'b0, lat, bcnt);
      chk("after_fin_latency", 64'(lat), 64'd4);

      // Reset in the middle of RUN.
      @(negedge clk);
      level_hv = data_a;
      start_encoding = 1'b1;
      @(negedge clk);
      start_encoding = 1'b0;
      @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valid", 64'(shifted_valid), 64'd0);
      chk("rst_hv_or", 64'(|shifted_hv), 64'd0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("rst_no_done", 64'(dcnt), 64'd0);
      run_op(onehot, 1'b0, lat, bcnt);
      chk("post_rst_latency", 64'(lat), 64'd4);
      chk("post_rst_ch9", shifted_hv[9], 64'h0000_0000_0002_0000);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
